// File: rtl/piso_pkg.sv
// Shared types for the parallel-in/serial-out transmitter.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } piso_state_t;

endpackage

// File: rtl/bit_tick_gen.sv
// Free-running divider with synchronous clear; ticks on the cycle its count reaches 'last'.
module bit_tick_gen #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] last,
    output logic             tick,
    output logic             pre_tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick     = (cnt_q == last);
        // Asserted one cycle ahead of tick so the parent can register tick-aligned outputs.
        pre_tick = (last != '0) && (cnt_q == last - CNT_W'(1));
        cnt_d    = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: one word per valid/ready handshake, each bit held
// CLKS_PER_BIT cycles, followed by an optional idle gap.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_BITS     = 0,
    parameter int MSB_FIRST    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             serial_out,
    output logic             frame_valid,
    output logic             done
);

    localparam int GAP_CYC = CLKS_PER_BIT * ((GAP_BITS > 1) ? GAP_BITS : 1);
    localparam int CNT_W   = $clog2((GAP_CYC > 2) ? GAP_CYC : 2);
    localparam int BIT_W   = $clog2(WIDTH);

    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] PENULT_BIT = BIT_W'(WIDTH - 2);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_BITS * CLKS_PER_BIT - 1);

    if (WIDTH < 2 || CLKS_PER_BIT < 1) begin : g_param_check
        $error("piso_serializer: WIDTH must be >= 2 and CLKS_PER_BIT >= 1");
    end

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             serial_q, serial_d;
    logic             frame_valid_q, frame_valid_d;
    logic             done_q, done_d;
    logic             tick, pre_tick;
    logic [CNT_W-1:0] tick_last;

    function automatic logic head(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    assign in_ready  = (state_q == IDLE);
    assign tick_last = (state_q == GAP) ? GAP_LAST : BIT_LAST;

    bit_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state_q == IDLE),
        .last     (tick_last),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d   = in_data;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // done is registered, so predict the last cycle of the last bit one cycle early.
                if (CLKS_PER_BIT == 1) begin
                    done_d = tick && (bit_cnt_q == PENULT_BIT);
                end else begin
                    done_d = pre_tick && (bit_cnt_q == LAST_BIT);
                end
                if (tick) begin
                    shreg_d = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                               : {1'b0, shreg_q[WIDTH-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = (GAP_BITS > 0) ? GAP : IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        frame_valid_d = (state_d == SHIFT);
        serial_d      = frame_valid_d && head(shreg_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            serial_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            serial_q      <= serial_d;
            frame_valid_q <= frame_valid_d;
            done_q        <= done_d;
        end
    end

    assign serial_out  = serial_q;
    assign frame_valid = frame_valid_q;
    assign done        = done_q;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out transmitter that sits directly upstream of shift_register and drives its serial_in.
- Accepts one WIDTH-bit word per valid/ready handshake.
- Emits the word one bit at a time, each bit held CLKS_PER_BIT cycles, followed by an optional idle gap.
- With defaults (WIDTH=8, CLKS_PER_BIT=1, MSB_FIRST=1), shift_register's parallel_out equals the accepted word one cycle after done.

Parameters:
WIDTH, 8, data word width; legal range >=2.
CLKS_PER_BIT, 1, clock cycles each serial bit is held; legal range >=1.
GAP_BITS, 0, idle bit-times inserted after each frame; legal range >=0.
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_data holds a word to send.
in_ready  output  1  block can accept a word this cycle.
in_data  input  WIDTH  parallel word; sampled only on handshake.
serial_out  output  1  serial bit stream; 0 when not transmitting.
frame_valid  output  1  high while a data bit is on serial_out.
done  output  1  one-cycle pulse on the last cycle of the last data bit.

Behaviour:
- Reset: clk is the only clock; rst_n asserts asynchronously and deasserts synchronously to clk. While rst_n=0:
  - state=IDLE; serial_out=0, frame_valid=0, done=0.
  - Shift register, bit counter and divider all 0.
  - in_ready=1, because it is decoded from state==IDLE.
- Reset mid-frame aborts the word immediately with no done pulse. The partial frame is not resumed.
- States: IDLE, SHIFT, GAP; encoded in the package enum.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid && in_ready: load in_data into the internal shift register, clear bit_cnt and div_cnt, go to SHIFT.
- SHIFT:
  - in_ready=0; frame_valid=1.
  - serial_out = current head bit: shreg[WIDTH-1] if MSB_FIRST=1, else shreg[0].
  - div_cnt counts 0..CLKS_PER_BIT-1. On wrap, shift shreg one position toward the head and increment bit_cnt.
  - When div_cnt==CLKS_PER_BIT-1 and bit_cnt==WIDTH-1: assert done this cycle. Next state is GAP if GAP_BITS>0, else IDLE.
- GAP:
  - serial_out=0, frame_valid=0, in_ready=0.
  - Stay GAP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Latency and throughput:
  - Handshake at edge k puts the first bit on serial_out after edge k.
  - Frame occupies exactly WIDTH*CLKS_PER_BIT cycles.
  - Next handshake occurs no earlier than the edge ending the first IDLE cycle after the frame/gap. Minimum word period is (WIDTH+GAP_BITS)*CLKS_PER_BIT+1 cycles.
- in_data changes after the handshake have no effect on the frame in progress.
- in_valid held high continuously: words are accepted back-to-back at the minimum period, with no word dropped or duplicated.
- in_valid low in IDLE: outputs stay at idle values indefinitely.
- All outputs except in_ready are registered. in_ready is combinational from state only and never depends on in_valid.
- Counter widths:
  - bit_cnt uses $clog2(WIDTH) bits.
  - div_cnt and gap counter use $clog2(max(CLKS_PER_BIT*max(GAP_BITS,1),2)) bits.
  - No counter wraps past its terminal value.
- Elaboration-time assertion fails if WIDTH<2 or CLKS_PER_BIT<1.

Decomposition:
- Package piso_pkg: state enum type piso_state_t (IDLE, SHIFT, GAP).
- Sub-module bit_tick_gen: CLKS_PER_BIT divider with clear input and one-cycle tick output. It is reused by the SHIFT and GAP timing.
- The FSM, shift register and bit counter stay in piso_serializer.

Test Plan:
1. Reset, defaults, send 8'hA5 → serial_out sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles; frame_valid high for exactly those 8 cycles; done on the 8th; shift_register parallel_out==8'hA5 one cycle after done.
2. MSB_FIRST=0, CLKS_PER_BIT=3, send 8'h01 → serial_out=1 for 3 cycles then 0 for 21 cycles; frame_valid high 24 cycles; in_ready low throughout.
3. in_valid held high, words 8'h3C then 8'hC3 (defaults) → second handshake exactly 9 cycles after the first; both words serialized intact; two done pulses 9 cycles apart.
4. GAP_BITS=2, CLKS_PER_BIT=2, back-to-back 8'hFF, 8'hFF → 16 cycles of 1, then 4 cycles of serial_out=0 with frame_valid=0, one IDLE cycle, then the next frame.
5. Change in_data to 8'h00 one cycle after accepting 8'hFF → all 8 transmitted bits are 1.
6. Assert rst_n=0 asynchronously after 4 bits of 8'h5A → serial_out, frame_valid and done go 0 without waiting for clk; in_ready=1; no done pulse; next word 8'h81 is transmitted correctly from its first bit.
